// File: rtl/audio_codec_deserializer.sv
// audio_codec_deserializer: left-justified codec ADC receiver; 16-bit L/R capture, one mono FIFO entry per frame.
// Latency: a sample enters the FIFO two clk after the 16th right-channel bit; audio_data/audio_valid appear one clk after fifo_rd_en.
// Backpressure: none toward the codec; a frame that finds the FIFO full is dropped and sets the sticky overflow flag.
//
// Ports:
//   clk, reset_n                      - system clock, synchronous active-low reset
//   bclk_rising_edge/_falling_edge    - single-clk bclk edge strobes (falling is reserved)
//   lrclk_rising_edge/_falling_edge   - single-clk lrclk edge strobes (rise = left channel starts)
//   i2s_adcdat                        - serial ADC data, already synchronised to clk
//   fifo_rd_en                        - pop one sample
//   overflow_clr                      - clears the overflow flag
//   audio_data, audio_valid           - popped sample and its one-cycle valid
//   fifo_empty/_full/_half_full       - FIFO occupancy flags
//   overflow                          - sticky dropped-sample flag
//
// Build option: define AUDIO_CODEC_DESERIALIZER_MONO_MIX_EN to push (L+R)>>>1 instead of L.
module audio_codec_deserializer #(
  parameter int DATA_WIDTH      = 16,
  parameter int FIFO_ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  bclk_rising_edge,
  input  logic                  bclk_falling_edge,
  input  logic                  lrclk_rising_edge,
  input  logic                  lrclk_falling_edge,
  input  logic                  i2s_adcdat,
  input  logic                  fifo_rd_en,
  input  logic                  overflow_clr,
  output logic [DATA_WIDTH-1:0] audio_data,
  output logic                  audio_valid,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  fifo_half_full,
  output logic                  overflow
);

  localparam int CW    = $clog2(DATA_WIDTH + 1);
  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam logic [CW-1:0]            LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [FIFO_ADDR_WIDTH:0] FULL_CNT = (FIFO_ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [FIFO_ADDR_WIDTH:0] HALF_CNT = (FIFO_ADDR_WIDTH + 1)'(DEPTH / 2);

  typedef enum logic [2:0] {
    IDLE,
    RX_LEFT,
    WAIT_RIGHT,
    RX_RIGHT,
    PUSH,
    WAIT_LEFT
  } state_t;

  state_t                  state_q;
  logic [CW-1:0]           bit_cnt_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic [DATA_WIDTH-1:0]   shift_d;
  logic [DATA_WIDTH-1:0]   left_q;
  logic                    overflow_q;
  logic [DATA_WIDTH-1:0]   push_dat;
`ifdef AUDIO_CODEC_DESERIALIZER_MONO_MIX_EN
  logic [DATA_WIDTH-1:0]   right_q;
`endif

  // FIFO storage
  logic [DATA_WIDTH-1:0]      mem_q [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q;
  logic [FIFO_ADDR_WIDTH:0]   count_q;
  logic [DATA_WIDTH-1:0]      audio_data_q;
  logic                       audio_valid_q;
  logic                       wr_en;
  logic                       rd_en;

  // MSB arrives first, so each new bit enters at the LSB end.
  assign shift_d = {shift_q[DATA_WIDTH-2:0], i2s_adcdat};

`ifdef AUDIO_CODEC_DESERIALIZER_MONO_MIX_EN
  // One extra bit of headroom makes the sum exact; the halved result always fits back in DATA_WIDTH.
  assign push_dat = DATA_WIDTH'(($signed({left_q[DATA_WIDTH-1], left_q}) +
                                 $signed({right_q[DATA_WIDTH-1], right_q})) >>> 1);
`else
  // The right channel is still clocked through shift_q for alignment but never stored.
  assign push_dat = left_q;
`endif

  assign fifo_empty     = (count_q == '0);
  assign fifo_full      = (count_q == FULL_CNT);
  assign fifo_half_full = (count_q >= HALF_CNT);
  // Full is judged on current occupancy, so a same-cycle pop never makes room for the push.
  assign wr_en          = (state_q == PUSH) && !fifo_full;
  assign rd_en          = fifo_rd_en && !fifo_empty;

  assign audio_data  = audio_data_q;
  assign audio_valid = audio_valid_q;
  assign overflow    = overflow_q;

  // Frame-alignment FSM. lrclk strobes are tested before bclk_rising_edge in every state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      left_q     <= '0;
`ifdef AUDIO_CODEC_DESERIALIZER_MONO_MIX_EN
      right_q    <= '0;
`endif
      overflow_q <= 1'b0;
    end else begin
      // Set beats clear when both happen together.
      if ((state_q == PUSH) && fifo_full) begin
        overflow_q <= 1'b1;
      end else if (overflow_clr) begin
        overflow_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (lrclk_rising_edge) begin
            state_q   <= RX_LEFT;
            bit_cnt_q <= '0;
          end
        end
        RX_LEFT: begin
          if (lrclk_falling_edge) begin
            state_q <= IDLE;           // short left channel: drop the frame
          end else if (lrclk_rising_edge) begin
            bit_cnt_q <= '0;           // new frame start: restart the left capture
          end else if (bclk_rising_edge) begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + CW'(1);
            if (bit_cnt_q == LAST_BIT) begin
              left_q  <= shift_d;
              state_q <= WAIT_RIGHT;
            end
          end
        end
        WAIT_RIGHT: begin
          if (lrclk_falling_edge) begin
            state_q   <= RX_RIGHT;
            bit_cnt_q <= '0;
          end else if (lrclk_rising_edge) begin
            state_q   <= RX_LEFT;
            bit_cnt_q <= '0;
          end
        end
        RX_RIGHT: begin
          if (lrclk_rising_edge) begin
            state_q   <= RX_LEFT;      // short right channel: drop frame, resync on the new one
            bit_cnt_q <= '0;
          end else if (lrclk_falling_edge) begin
            state_q <= IDLE;
          end else if (bclk_rising_edge) begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + CW'(1);
            if (bit_cnt_q == LAST_BIT) begin
`ifdef AUDIO_CODEC_DESERIALIZER_MONO_MIX_EN
              right_q <= shift_d;
`endif
              state_q <= PUSH;
            end
          end
        end
        PUSH: begin
          // The FIFO write is decoded from this state; here only the next state is chosen.
          if (lrclk_rising_edge) begin
            state_q   <= RX_LEFT;
            bit_cnt_q <= '0;
          end else begin
            state_q <= WAIT_LEFT;
          end
        end
        WAIT_LEFT: begin
          if (lrclk_rising_edge) begin
            state_q   <= RX_LEFT;
            bit_cnt_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Storage array carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      audio_data_q  <= '0;
      audio_valid_q <= 1'b0;
    end else begin
      audio_valid_q <= rd_en;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + FIFO_ADDR_WIDTH'(1);
      end
      if (rd_en) begin
        audio_data_q <= mem_q[rd_ptr_q];
        rd_ptr_q     <= rd_ptr_q + FIFO_ADDR_WIDTH'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (FIFO_ADDR_WIDTH + 1)'(1);
        2'b01:   count_q <= count_q - (FIFO_ADDR_WIDTH + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // bclk edges are mutually exclusive; both strobes at once means a broken edge detector upstream.
  a_bclk_edges_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
                                           !(bclk_rising_edge && bclk_falling_edge));

endmodule

// File: doc/audio_codec_deserializer.md
Name: audio_codec_deserializer

Overview:
Receive path of the codec interface: captures the codec ADC serial stream (ADCDAT) into parallel 16-bit samples and buffers them in a FIFO for the audio processing logic.
- Format is left-justified: lrclk high = left channel, MSB first, MSB valid on the first bclk rising edge after the lrclk transition.
- Consumes the same single-cycle bclk/lrclk edge strobes as the transmit serializer.
- Mono output: one FIFO entry per complete L/R frame.

Parameters:
DATA_WIDTH, 16, bits per channel sample.
FIFO_ADDR_WIDTH, 6, FIFO depth = 2^FIFO_ADDR_WIDTH entries (64).

Ports:
clk  in  1  system clock; all logic on posedge clk.
reset_n  in  1  reset, synchronous, active-low.
bclk_rising_edge  in  1  one-clk strobe, bclk rose.
bclk_falling_edge  in  1  one-clk strobe, bclk fell; unused, reserved.
lrclk_rising_edge  in  1  one-clk strobe, lrclk rose (left channel starts).
lrclk_falling_edge  in  1  one-clk strobe, lrclk fell (right channel starts).
i2s_adcdat  in  1  serial data from codec, already synchronised to clk.
fifo_rd_en  in  1  pop one sample.
overflow_clr  in  1  clears the overflow flag.
audio_data  out  DATA_WIDTH  FIFO read data.
audio_valid  out  1  audio_data valid this cycle.
fifo_empty  out  1  FIFO empty.
fifo_full  out  1  FIFO full.
fifo_half_full  out  1  FIFO at least half full.
overflow  out  1  sticky flag: a sample was dropped because the FIFO was full.

Behaviour:
- Reset: state=IDLE, bit_cnt=0, shift/left/right registers=0, overflow=0, audio_valid=0, FIFO emptied (fifo_empty=1, full=0, half_full=0). Reset mid-frame discards the partial frame.
- Clocking: bclk period >= 4 clk. lrclk strobes coincide with bclk falling strobes and never with bclk rising strobes.
- Priority: if any strobes coincide, lrclk strobes take priority over bclk_rising_edge.
- Shift rule: on bclk_rising_edge in RX_LEFT or RX_RIGHT, shift = {shift[DATA_WIDTH-2:0], i2s_adcdat} and bit_cnt++.
- States:
  - IDLE: wait for frame alignment. lrclk_rising_edge -> RX_LEFT with bit_cnt=0. All other strobes are ignored.
  - RX_LEFT: shift on each bclk_rising_edge.
    - When bit_cnt reaches DATA_WIDTH: latch left=shift -> WAIT_RIGHT.
    - lrclk_falling_edge before completion -> IDLE (short frame dropped, nothing pushed).
  - WAIT_RIGHT: extra bits beyond DATA_WIDTH are ignored.
    - lrclk_falling_edge -> RX_RIGHT with bit_cnt=0.
    - lrclk_rising_edge -> RX_LEFT with bit_cnt=0 (resync).
  - RX_RIGHT: shift as above.
    - When bit_cnt reaches DATA_WIDTH: latch right=shift -> PUSH.
    - lrclk_rising_edge before completion -> RX_LEFT with bit_cnt=0 (frame dropped).
  - PUSH: one cycle.
    - If !fifo_full: FIFO wr_en=1 with the push value. Else overflow<=1 and the sample is dropped.
    - Next state is WAIT_LEFT, or RX_LEFT (bit_cnt=0) if lrclk_rising_edge occurs in the same cycle; the push still happens.
  - WAIT_LEFT: lrclk_rising_edge -> RX_LEFT with bit_cnt=0.
- Push value (feature off): left sample; the right sample is captured but discarded.
- Read side:
  - audio_data is the FIFO data_out and is valid the cycle after fifo_rd_en.
  - audio_valid <= fifo_rd_en & !fifo_empty, registered, so it is high for exactly that one cycle.
  - fifo_rd_en while empty: ignored, audio_valid stays 0.
- Simultaneous FIFO read and write: both take effect; occupancy is unchanged. A write in the same cycle a read frees a slot is not needed, because full is evaluated before the read.
- overflow: set in PUSH when fifo_full. overflow_clr clears it. If set and clear occur in the same cycle, set wins.

Optional Feature:
Macro AUDIO_CODEC_DESERIALIZER_MONO_MIX_EN.
- Defined: push value = (L + R) >>> 1. Operands are sign-extended to DATA_WIDTH+1 bits, shifted arithmetically, and truncated to DATA_WIDTH bits (this cannot overflow).
- Undefined: push value = left sample only; no adder is synthesised.

Test Plan:
1. Reset held 3 cycles with random strobes -> audio_valid=0, overflow=0, fifo_empty=1, fifo_full=0; no FIFO writes.
2. One frame L=0xA5C3, R=0x1234, 32 bclk per channel, bclk = clk/8 -> exactly one write; fifo_rd_en pulse -> next cycle audio_valid=1, audio_data=0xA5C3, then fifo_empty=1.
3. Reset released while lrclk low, mid right channel -> partial frame ignored; first popped sample is the left value of the first frame after lrclk rises (0x0F0F).
4. lrclk falls after only 10 left bits, then full frame L=0x1357 -> exactly one FIFO entry, value 0x1357.
5. 65 frames (L = frame index 1..65), no reads -> fifo_full after 64, fifo_half_full from 32, overflow=1 at frame 65; first pop returns 0x0001, last pop returns 0x0040; overflow_clr pulse -> overflow=0.
6. With AUDIO_CODEC_DESERIALIZER_MONO_MIX_EN: L=0x7FFE, R=0x0002 -> 0x4000; L=0x8000, R=0xFFFE -> 0xBFFF. Without the macro the same frames yield 0x7FFE and 0x8000.
